// File: rtl/awgn_pkg.sv
// awgn_pkg: shared constants for the taus88 uniform generator pair.
//   - default seeds (slot order A0,A1,A2,B0,B1,B2; index 0 = A0)
//   - per-slot minimum (a seed word must be strictly greater than this)
//   - warm-up length, per-component step masks and shift amounts
//   - FSM state enum
package awgn_pkg;

  localparam int SEED_W        = 32;
  localparam int NUM_SLOTS     = 6;
  localparam int WARMUP_CYCLES = 16;
  localparam int WARM_CNT_W    = $clog2(WARMUP_CYCLES);

  localparam logic [NUM_SLOTS-1:0][SEED_W-1:0] DEF_SEEDS = {
    32'h8BADF00D, 32'hCAFEF00D, 32'hDEADBEEF,   // B2 B1 B0
    32'h0F1E2D3C, 32'h9ABCDEF0, 32'h12345678    // A2 A1 A0
  };

  // Component k of either generator needs s > MIN; lower values collapse
  // the LFSR into a short or all-zero cycle.
  localparam logic [NUM_SLOTS-1:0][SEED_W-1:0] MIN_SEEDS = {
    32'd15, 32'd7, 32'd1,
    32'd15, 32'd7, 32'd1
  };

  // s' = ((s & MASK) << S) ^ (((s << Q) ^ s) >> R), per component 0..2
  localparam logic [2:0][SEED_W-1:0] STEP_MASK = {32'hFFFFFFF0, 32'hFFFFFFF8, 32'hFFFFFFFE};
  localparam logic [2:0][4:0]        STEP_Q    = {5'd3,  5'd2,  5'd13};
  localparam logic [2:0][4:0]        STEP_S    = {5'd17, 5'd4,  5'd12};
  localparam logic [2:0][4:0]        STEP_R    = {5'd11, 5'd25, 5'd19};

  typedef enum logic [1:0] {
    ST_WARM = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

endpackage

// File: rtl/taus_step.sv
// taus_step: one combinational taus88 advance of a three-component state,
// plus the generator output for the *current* state.
//   s_i      : current components s0,s1,s2 (index 0 = s0)
//   s_nxt_o  : stepped components
//   x_o      : s0 ^ s1 ^ s2 of s_i
module taus_step
  import awgn_pkg::*;
(
  input  logic [2:0][SEED_W-1:0] s_i,
  output logic [2:0][SEED_W-1:0] s_nxt_o,
  output logic [SEED_W-1:0]      x_o
);

  for (genvar c = 0; c < 3; c++) begin : g_comp
    assign s_nxt_o[c] = ((s_i[c] & STEP_MASK[c]) << STEP_S[c])
                      ^ (((s_i[c] << STEP_Q[c]) ^ s_i[c]) >> STEP_R[c]);
  end

  assign x_o = s_i[0] ^ s_i[1] ^ s_i[2];

endmodule

// File: rtl/taus_urng.sv
// taus_urng: dual taus88 uniform source feeding the Box-Muller stage.
//   clk, rst             : clock, async active-high reset
//   seed_valid/seed_data : six seed words, order A0,A1,A2,B0,B1,B2
//   seed_ready           : high in RUN and LOAD
//   seed_err             : one-cycle pulse after the 6th word if any word
//                          was below its minimum and replaced by its default
//   out_valid/out_ready  : sample handshake (valid only in RUN)
//   u0                   : {xa, xb[31:16]} for the log/sqrt path
//   u1                   : xb[15:0] angle for cosp
module taus_urng
  import awgn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [31:0] seed_data,
  output logic        seed_ready,
  output logic        seed_err,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [47:0] u0,
  output logic [15:0] u1
);

  // gen_*[0] = generator A, gen_*[1] = generator B
  logic [1:0][2:0][SEED_W-1:0] gen_q, gen_d, gen_nxt;
  logic [1:0][SEED_W-1:0]      x;

  state_e                      state_q, state_d;
  logic [WARM_CNT_W-1:0]       warm_cnt_q, warm_cnt_d;
  logic [2:0]                  word_cnt_q, word_cnt_d;
  // Words 0..4 shift in from the top; after five captures buf_q[0] = A0.
  logic [4:0][SEED_W-1:0]      buf_q, buf_d;
  logic                        seed_err_q, seed_err_d;

  logic [NUM_SLOTS-1:0][SEED_W-1:0] seeds_raw, seeds_fix;
  logic [NUM_SLOTS-1:0]             seed_bad;
  logic                             out_fire, seed_fire;

  for (genvar g = 0; g < 2; g++) begin : g_gen
    taus_step u_step (
      .s_i     (gen_q[g]),
      .s_nxt_o (gen_nxt[g]),
      .x_o     (x[g])
    );
  end

  // Sixth word is taken straight from the bus in its handshake cycle.
  assign seeds_raw = {seed_data, buf_q};

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_fix
    assign seed_bad[i]  = (seeds_raw[i] <= MIN_SEEDS[i]);
    assign seeds_fix[i] = seed_bad[i] ? DEF_SEEDS[i] : seeds_raw[i];
  end

  assign out_valid  = (state_q == ST_RUN);
  assign seed_ready = (state_q != ST_WARM);
  assign seed_err   = seed_err_q;
  assign out_fire   = out_valid & out_ready;
  assign seed_fire  = seed_valid & seed_ready;

  assign u0 = {x[0], x[1][31:16]};
  assign u1 = x[1][15:0];

  always_comb begin
    state_d    = state_q;
    gen_d      = gen_q;
    warm_cnt_d = warm_cnt_q;
    word_cnt_d = word_cnt_q;
    buf_d      = buf_q;
    seed_err_d = 1'b0;

    case (state_q)
      ST_WARM: begin
        gen_d = gen_nxt;
        if (warm_cnt_q == WARM_CNT_W'(WARMUP_CYCLES - 1)) begin
          warm_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // A sample transfer and a seed capture may coincide; both happen.
        if (out_fire) gen_d = gen_nxt;
        if (seed_fire) begin
          buf_d      = {seed_data, buf_q[4:1]};
          word_cnt_d = 3'd1;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (seed_valid) begin
          if (word_cnt_q == 3'd5) begin
            gen_d      = seeds_fix;
            seed_err_d = |seed_bad;
            word_cnt_d = '0;
            warm_cnt_d = '0;
            state_d    = ST_WARM;
          end else begin
            buf_d      = {seed_data, buf_q[4:1]};
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_WARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WARM;
      gen_q      <= DEF_SEEDS;
      warm_cnt_q <= '0;
      word_cnt_q <= '0;
      buf_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_d;
      warm_cnt_q <= warm_cnt_d;
      word_cnt_q <= word_cnt_d;
      buf_q      <= buf_d;
      seed_err_q <= seed_err_d;
    end
  end

endmodule
